instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Boot-time program loader: the write-side master of the instruction memory.
- Consumes a byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port (we/addr/din), holds the core in `busy` until loading finishes, then sends one acknowledge byte to the UART transmitter.
- Sits between uart_rx/uart_tx and the instruction memory; after `done` the core owns the memory.

Parameters:
- ADDRW, 10, word-address width of the instruction memory; capacity = 2^ADDRW words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-aligned.
- ACK_BYTE, 8'hAA, byte transmitted after the last word is written.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure, always accepted while consuming
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  32  byte address for the write, valid with mem_we
- mem_din  out  32  instruction word, valid with mem_we
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  byte offer; held until tx_ready
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready
- busy  out  1  high from reset until done; core is held while high
- done  out  1  high once the ack is accepted; sticky until reset
- overflow  out  1  sticky; set if the header word count exceeds 2^ADDRW

Behaviour:
- Reset, asynchronous and active-low: mem_we=0, mem_addr=BASE_ADDR, mem_din=0, tx_valid=0, tx_data=ACK_BYTE, busy=1, done=0, overflow=0, state=S_LEN, byte and word counters=0.
- Stream format: 4-byte little-endian word count N, then N words, each 4 bytes, little-endian (first byte goes to din[7:0]).
- Byte assembly: a 2-bit byte counter advances on each accepted rx_valid. The 4th byte completes the word.
- S_LEN:
  - On the 4th byte, latch N.
  - If N > 2^ADDRW, set overflow.
  - If N==0, go to S_ACK; else go to S_DATA.
- S_DATA:
  - The cycle after a word's 4th byte is accepted: mem_we=1 for exactly one cycle, with mem_din=word and mem_addr=BASE_ADDR+4*w, where w is the word index.
  - mem_addr advances by 4 in the cycle after the pulse.
  - Words with index >= 2^ADDRW are consumed but not written (mem_we stays 0) and are still counted.
  - After word N-1 is handled, go to S_ACK.
- S_ACK:
  - tx_valid=1, tx_data=ACK_BYTE.
  - On tx_valid && tx_ready: tx_valid=0, busy=0, done=1, go to S_DONE.
  - rx_valid in this state is ignored.
- S_DONE: terminal state. All rx_valid is ignored; outputs are stable. Only reset restarts loading.
- Latency: 4th byte strobe at cycle t gives the mem_we pulse at t+1. The final write at t+1 gives tx_valid at t+2.
- Back-to-back rx_valid on every cycle is legal. The word-complete write and the next word's first byte may coincide, and both must be handled.
- Word counter is 32 bits, so there is no wrap for any legal N. mem_addr is computed modulo 2^32.
- Reset asserted mid-load aborts immediately: a partial word is discarded and no mem_we is issued.

Decomposition:
- Package loader_pkg contains:
  - state encoding S_LEN, S_DATA, S_ACK, S_DONE;
  - BYTES_PER_WORD=4;
  - default ACK_BYTE.
- Sub-module byte_assembler:
  - inputs: clk, rstn, byte, strobe, clear;
  - outputs: 32-bit word and a one-cycle word_valid;
  - shared by the header phase and the data phase.

Test Plan:
- Header 02 00 00 00, data 13 00 00 00, 93 00 10 00 -> mem_we pulses with (addr 0x0, din 0x00000013), then (addr 0x4, din 0x00100093); then tx_valid with tx_data=0xAA; on tx_ready, done=1 and busy=0.
- Header N=0 -> no mem_we; tx_valid asserted the cycle after the 4th header byte; done after tx_ready.
- rx_valid on every cycle, N=3 -> exactly 3 write pulses at consecutive addresses; no byte lost.
- With ADDRW=2, N=5 -> overflow=1; 4 writes (addr 0x0 to 0xC); 5th word consumed without mem_we; ack is still sent.
- Reset after 2 data bytes, then full stream N=1 word 0xDEADBEEF -> single write to BASE_ADDR with din 0xDEADBEEF; no stale bytes.
- tx_ready held low for 10 cycles in S_ACK -> tx_valid and tx_data stable and busy=1 throughout; extra rx_valid bytes ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_ACK,
        S_DONE
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] DEF_ACK_BYTE   = 8'hAA;

endpackage

// File: rtl/byte_assembler.sv
// Packs a strobed byte stream into little-endian 32-bit words.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_byte,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [31:0] word_next,
    output logic        complete
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt;
    logic [23:0] acc;

    // Same-cycle view of the completing word, for the header phase
    assign complete  = strobe && (cnt == LAST);
    assign word_next = {rx_byte, acc};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            acc        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= complete && !clear;
            if (clear) begin
                cnt <= '0;
            end else if (strobe) begin
                cnt <= cnt + 2'd1;
                unique case (cnt)
                    2'd0: acc[7:0]   <= rx_byte;
                    2'd1: acc[15:8]  <= rx_byte;
                    2'd2: acc[23:16] <= rx_byte;
                    2'd3: word       <= word_next;
                endcase
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: UART byte stream -> instruction memory writes, then one ack byte.
module instr_loader
    import loader_pkg::*;
#(
    parameter int         ADDRW     = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  ACK_BYTE  = DEF_ACK_BYTE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [32:0] CAP  = 33'(1) << ADDRW;
    localparam logic [31:0] STEP = 32'(BYTES_PER_WORD);

    state_t      state;
    state_t      state_nx;
    logic [31:0] n_words;
    logic [31:0] w_idx;
    logic [31:0] word;
    logic [31:0] word_next;
    logic        word_valid;
    logic        complete;
    logic        clear;
    logic        hdr_done;
    logic        data_word;

    assign hdr_done  = (state == S_LEN) && complete;
    assign data_word = (state == S_DATA) && word_valid;
    // Header is consumed on its 4th byte so it never surfaces as a data word
    assign clear     = hdr_done || (state == S_ACK) || (state == S_DONE);

    byte_assembler u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .rx_byte    (rx_data),
        .strobe     (rx_valid),
        .clear      (clear),
        .word       (word),
        .word_valid (word_valid),
        .word_next  (word_next),
        .complete   (complete)
    );

    assign mem_din = word;
    assign tx_data = ACK_BYTE;

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        tx_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            S_LEN: begin
                if (complete)
                    state_nx = (word_next == '0) ? S_ACK : S_DATA;
            end
            S_DATA: begin
                if (word_valid) begin
                    mem_we = ({1'b0, w_idx} < CAP);
                    if (w_idx == n_words - 32'd1)
                        state_nx = S_ACK;
                end
            end
            S_ACK: begin
                tx_valid = 1'b1;
                if (tx_ready)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_LEN;
            n_words  <= '0;
            w_idx    <= '0;
            mem_addr <= BASE_ADDR;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (hdr_done) begin
                n_words <= word_next;
                if ({1'b0, word_next} > CAP)
                    overflow <= 1'b1;
            end
            if (data_word) begin
                w_idx    <= w_idx + 32'd1;
                mem_addr <= mem_addr + STEP;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader (ADDRW=2 to reach overflow).
module tb_instr_loader;

    localparam int ADDRW = 2;
    localparam int CAP   = 1 << ADDRW;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    instr_loader #(
        .ADDRW     (ADDRW),
        .BASE_ADDR (32'h0000_0000),
        .ACK_BYTE  (8'hAA)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[16];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (rstn === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_write: got addr %h din %h expected none",
                         mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_din", mem_din, e.din);
            end
        end
    end

    task automatic reset_dut();
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send_word(input logic [31:0] v, input bit gaps);
        for (int i = 0; i < 4; i++)
            send_byte(v[8*i +: 8], gaps);
    endtask

    task automatic run_load(input int n, input bit gaps, input int hold);
        send_word(32'(n), gaps);
        for (int i = 0; i < n; i++) begin
            send_word(words[i], gaps);
            if (i < CAP)
                exp_q.push_back('{addr: 32'(4 * i), din: words[i]});
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("tx_valid_latency1", 32'(tx_valid), 32'(n == 0));
        if (n > 0) begin
            @(negedge clk);
            check("tx_valid_latency2", 32'(tx_valid), 32'd1);
        end
        for (int c = 0; c < hold; c++) begin
            check("ack_hold_valid", 32'(tx_valid), 32'd1);
            check("ack_hold_data", 32'(tx_data), 32'h0000_00AA);
            check("ack_hold_busy", 32'(busy), 32'd1);
            check("ack_hold_done", 32'(done), 32'd0);
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        check("ack_valid", 32'(tx_valid), 32'd1);
        check("ack_data", 32'(tx_data), 32'h0000_00AA);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("done", 32'(done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("tx_valid_after", 32'(tx_valid), 32'd0);
        check("overflow", 32'(overflow), 32'(n > CAP));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        if (n <= CAP)
            check("final_addr", mem_addr, 32'(4 * n));
        repeat (5) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("done_sticky", 32'(done), 32'd1);
        check("tx_idle_done", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        reset_dut();
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_din", mem_din, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h0000_00AA);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        run_load(2, 1'b1, 3);

        reset_dut();
        run_load(0, 1'b1, 2);

        reset_dut();
        for (int i = 0; i < 3; i++)
            words[i] = $urandom;
        run_load(3, 1'b0, 0);

        reset_dut();
        for (int i = 0; i < 5; i++)
            words[i] = $urandom;
        run_load(5, 1'b0, 1);

        // Abort mid-word: partial bytes must not leak into the next load
        reset_dut();
        send_word(32'd1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_addr", mem_addr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        words[0] = 32'hDEAD_BEEF;
        run_load(1, 1'b0, 10);

        for (int r = 0; r < 8; r++) begin
            reset_dut();
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++)
                words[i] = $urandom;
            run_load(n, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
